mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 32-bit-block data memory between the data cache (port D, read/write) and the instruction cache (port I, read-only).
- Sits between both cache controllers' memory-side interfaces and the memory module.
- Presents each cache with an unchanged read/write/busywait handshake.
- Serialises accesses with round-robin fairness and holds a grant until the memory access completes.

Parameters:
ADDR_W, 6, block address width (tag+index)
DATA_W, 32, block width in bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
d_read  in  1  data-cache block read request
d_write  in  1  data-cache block write-back request
d_address  in  ADDR_W  data-cache block address
d_writedata  in  DATA_W  write-back block
d_readdata  out  DATA_W  block returned to data cache
d_busywait  out  1  stall to data cache
i_read  in  1  instruction-cache block read request
i_address  in  ADDR_W  instruction-cache block address
i_readdata  out  DATA_W  block returned to instruction cache
i_busywait  out  1  stall to instruction cache
mem_read  out  1  memory read strobe (registered)
mem_write  out  1  memory write strobe (registered)
mem_address  out  ADDR_W  memory block address (registered)
mem_writedata  out  DATA_W  memory write block (registered)
mem_readdata  in  DATA_W  memory read block
mem_busywait  in  1  memory busy

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock. All state updates on posedge clock.
- FSM states: IDLE, ISSUE, WAIT, DONE. Registers: grant (0=D, 1=I), last_grant, op_write, rdata_q.
- IDLE:
  - d_req = d_read|d_write; i_req = i_read.
  - If only one port requests, grant it.
  - If both request, grant the port != last_grant.
  - On a grant: latch the address; latch writedata (D write only); set mem_read/mem_write; go to ISSUE.
  - d_read and d_write both high is illegal; write takes precedence.
- ISSUE: exactly one cycle, mem_busywait ignored (covers the memory's combinational busy assertion). Go to WAIT.
- WAIT:
  - Hold mem_* outputs.
  - When mem_busywait==0 at a posedge: capture mem_readdata into rdata_q (reads only); clear mem_read/mem_write; last_grant<=grant; go to DONE.
- DONE: one cycle, then IDLE.
- Requester busywait (combinational):
  - d_busywait = d_req && !(state==DONE && grant==0).
  - i_busywait = i_req && !(state==DONE && grant==1).
  - A non-requesting port sees busywait 0.
- d_readdata = i_readdata = rdata_q. Valid in DONE for the granted port; otherwise holds the last value.
- Latency: request seen in IDLE at edge 0 → mem strobe from edge 1 → with an N-cycle memory, busywait low in DONE ≈ N+2 cycles after the request. Minimum arbitration overhead is 3 cycles.
- No preemption: a request arriving on the other port during ISSUE/WAIT/DONE waits. It is granted at the first IDLE evaluation after DONE, so there is no back-to-back starvation.
- A requester dropping its request mid-access is illegal. The arbiter still completes the memory access.
- Reset (asserted in any state, including mid-access):
  - State goes to IDLE.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - rdata_q=0, grant=0.
  - last_grant=1, so D wins the first tie.
  - Busywaits follow the combinational rule (=request).
  - An in-flight memory access is abandoned; the memory is responsible for its own reset.

Decomposition:
- Shared package: state encodings (IDLE/ISSUE/WAIT/DONE), PORT_D=0 / PORT_I=1 constants, ADDR_W/DATA_W defaults.
- Optional sub-module rr_pick2: combinational 2-way round-robin chooser (req[1:0], last → grant, valid).
- FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Reset, then d_read=1, d_address=6'h05, memory busy 5 cycles returning 32'hDEADBEEF → mem_read high with mem_address=05 from the next edge; d_readdata=DEADBEEF and d_busywait=0 in DONE; i_busywait stays 0.
- i_read=1, i_address=6'h3F, alone → single memory read at 3F; i_readdata=result; mem_write never asserted.
- d_write=1, d_address=6'h12, d_writedata=32'h01234567 → mem_write=1, mem_address=12, mem_writedata=01234567 held through WAIT; cleared in DONE.
- d_read and i_read both asserted in the same cycle after reset → D served first, I served immediately after. Repeat with both requests persisting → service alternates D, I, D, I.
- I granted, d_read raised during WAIT → mem_address stays on the I address until completion; d_busywait held 1 until its own DONE.
- reset asserted during WAIT of a D write → next edge: mem_write=0, state IDLE, rdata_q=0. After reset release, a pending i_read is granted before a simultaneous d_read is not required: with both pending, D wins because last_grant=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port identifiers used for grant/last_grant, and default bus widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    // Port identifiers as stored in grant / last_grant
    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the data-cache side, instruction-cache side and memory side of the
// arbiter.
//   slave  : arbiter view (takes cache requests and memory responses,
//            drives cache responses and memory strobes)
//   master : environment view (caches + memory model)
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // Data cache (read / write-back)
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;
    // Instruction cache (read only)
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;
    // Memory
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;

    modport slave (
        input  d_read, d_write, d_address, d_writedata,
        output d_readdata, d_busywait,
        input  i_read, i_address,
        output i_readdata, i_busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport master (
        output d_read, d_write, d_address, d_writedata,
        input  d_readdata, d_busywait,
        output i_read, i_address,
        input  i_readdata, i_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// mem_arbiter_rr_pick2
// Combinational 2-way round-robin chooser.
//   req[0] = port D request, req[1] = port I request
//   last   = port granted most recently
//   grant  = chosen port (valid only when valid=1)
//   valid  = at least one request present
module mem_arbiter_rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // On a tie the port that did not win last time is chosen
    always_comb begin
        valid = |req;
        grant = PORT_D;
        case (req)
            2'b01:   grant = PORT_D;
            2'b10:   grant = PORT_I;
            2'b11:   grant = ~last;
            default: grant = PORT_D;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one block memory between the data cache (port D, read/write) and
// the instruction cache (port I, read only). Accesses are serialised with
// round-robin fairness; a grant is held until the memory access finishes.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : cache-side handshakes and memory-side strobes (slave view)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    arb_state_t        state_r, state_nxt_s;
    logic              grant_r, grant_nxt_s;
    logic              last_grant_r, last_grant_nxt_s;
    logic              op_write_r, op_write_nxt_s;
    logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
    logic              mem_read_r, mem_read_nxt_s;
    logic              mem_write_r, mem_write_nxt_s;
    logic [ADDR_W-1:0] mem_address_r, mem_address_nxt_s;
    logic [DATA_W-1:0] mem_writedata_r, mem_writedata_nxt_s;

    logic d_req_s, i_req_s;
    logic pick_grant_s, pick_valid_s;

    assign d_req_s = bus.d_read | bus.d_write;
    assign i_req_s = bus.i_read;

    mem_arbiter_rr_pick2 u_pick (
        .req   ({i_req_s, d_req_s}),
        .last  (last_grant_r),
        .grant (pick_grant_s),
        .valid (pick_valid_s)
    );

    // Next-state and datapath next values
    always_comb begin
        state_nxt_s         = state_r;
        grant_nxt_s         = grant_r;
        last_grant_nxt_s    = last_grant_r;
        op_write_nxt_s      = op_write_r;
        rdata_nxt_s         = rdata_r;
        mem_read_nxt_s      = mem_read_r;
        mem_write_nxt_s     = mem_write_r;
        mem_address_nxt_s   = mem_address_r;
        mem_writedata_nxt_s = mem_writedata_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_nxt_s = pick_grant_s;
                    state_nxt_s = ISSUE;
                    if (pick_grant_s == PORT_I) begin
                        mem_address_nxt_s = bus.i_address;
                        mem_read_nxt_s    = 1'b1;
                        mem_write_nxt_s   = 1'b0;
                        op_write_nxt_s    = 1'b0;
                    end else if (bus.d_write) begin
                        // Write wins if the data cache raises both strobes
                        mem_address_nxt_s   = bus.d_address;
                        mem_writedata_nxt_s = bus.d_writedata;
                        mem_read_nxt_s      = 1'b0;
                        mem_write_nxt_s     = 1'b1;
                        op_write_nxt_s      = 1'b1;
                    end else begin
                        mem_address_nxt_s = bus.d_address;
                        mem_read_nxt_s    = 1'b1;
                        mem_write_nxt_s   = 1'b0;
                        op_write_nxt_s    = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            // Memory may raise busywait combinationally off the new strobe,
            // so its busy line is not trusted for one cycle.
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (!bus.mem_busywait) begin
                    if (!op_write_r) begin
                        rdata_nxt_s = bus.mem_readdata;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                    mem_read_nxt_s   = 1'b0;
                    mem_write_nxt_s  = 1'b0;
                    last_grant_nxt_s = grant_r;
                    state_nxt_s      = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant bookkeeping, read-data holding register and memory-side strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_r         <= PORT_D;
            last_grant_r    <= PORT_I;
            op_write_r      <= 1'b0;
            rdata_r         <= {DATA_W{1'b0}};
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_address_r   <= {ADDR_W{1'b0}};
            mem_writedata_r <= {DATA_W{1'b0}};
        end else begin
            grant_r         <= grant_nxt_s;
            last_grant_r    <= last_grant_nxt_s;
            op_write_r      <= op_write_nxt_s;
            rdata_r         <= rdata_nxt_s;
            mem_read_r      <= mem_read_nxt_s;
            mem_write_r     <= mem_write_nxt_s;
            mem_address_r   <= mem_address_nxt_s;
            mem_writedata_r <= mem_writedata_nxt_s;
        end
    end

    // A requester is released only in DONE of its own grant
    always_comb begin
        bus.d_busywait = d_req_s && !((state_r == DONE) && (grant_r == PORT_D));
        bus.i_busywait = i_req_s && !((state_r == DONE) && (grant_r == PORT_I));
    end

    assign bus.d_readdata    = rdata_r;
    assign bus.i_readdata    = rdata_r;
    assign bus.mem_read      = mem_read_r;
    assign bus.mem_write     = mem_write_r;
    assign bus.mem_address   = mem_address_r;
    assign bus.mem_writedata = mem_writedata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a fixed-latency block memory model.
module tb_mem_arbiter;

    localparam int MEM_LAT = 5;
    localparam int BOUND   = 60;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: busy from the first strobe cycle, MEM_LAT cycles of latency
    logic [31:0] mem_q [0:63];
    logic        started;
    int          cnt;
    int          write_cnt = 0;

    assign bus.mem_readdata = mem_q[bus.mem_address];
    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && !(started && cnt == 0);

    always @(posedge clock) begin
        if (bus.mem_write) write_cnt <= write_cnt + 1;
        if (reset) begin
            started   <= 1'b0;
            cnt       <= 0;
            mem_q[5]  <= 32'hDEADBEEF;
            mem_q[63] <= 32'hCAFEF00D;
        end else if ((bus.mem_read || bus.mem_write) && !started) begin
            started <= 1'b1;
            cnt     <= MEM_LAT - 1;
        end else if (started && cnt != 0) begin
            cnt <= cnt - 1;
        end else if (started) begin
            started <= 1'b0;
            if (bus.mem_write) mem_q[bus.mem_address] <= bus.mem_writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (negedge by negedge) until the given port's busywait drops
    task automatic wait_free(input logic port_i, input int start, output int cycles);
        logic done;
        done   = 1'b0;
        cycles = start;
        while (!done && cycles < BOUND) begin
            @(negedge clock);
            cycles++;
            if (!(port_i ? bus.i_busywait : bus.d_busywait)) done = 1'b1;
        end
        check("wait_bound", done, 1'b1);
    endtask

    int cyc;
    int wc0;
    int port_seen;
    logic done_l;

    initial begin
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = 6'h00;
        bus.d_writedata = 32'h0; bus.i_read = 1'b0; bus.i_address = 6'h00;
        repeat (3) @(negedge clock);
        check("rst_mem_read",  bus.mem_read,      1'b0);
        check("rst_mem_write", bus.mem_write,     1'b0);
        check("rst_mem_addr",  bus.mem_address,   6'h00);
        check("rst_mem_wdata", bus.mem_writedata, 32'h0);
        check("rst_rdata",     bus.d_readdata,    32'h0);
        check("rst_d_busy",    bus.d_busywait,    1'b0);
        check("rst_i_busy",    bus.i_busywait,    1'b0);
        reset = 1'b0;
        @(negedge clock);

        // 1: D read at 05
        bus.d_read = 1'b1; bus.d_address = 6'h05;
        @(negedge clock);
        check("t1_mem_read", bus.mem_read,    1'b1);
        check("t1_mem_addr", bus.mem_address, 6'h05);
        check("t1_d_busy",   bus.d_busywait,  1'b1);
        check("t1_i_busy",   bus.i_busywait,  1'b0);
        wait_free(1'b0, 1, cyc);
        check("t1_latency",  cyc,             7);
        check("t1_rdata",    bus.d_readdata,  32'hDEADBEEF);
        check("t1_rd_clr",   bus.mem_read,    1'b0);
        check("t1_i_busy2",  bus.i_busywait,  1'b0);
        bus.d_read = 1'b0;
        @(negedge clock);
        check("t1_idle_busy", bus.d_busywait, 1'b0);

        // 2: I read at 3F alone
        wc0 = write_cnt;
        bus.i_read = 1'b1; bus.i_address = 6'h3F;
        @(negedge clock);
        check("t2_mem_read", bus.mem_read,    1'b1);
        check("t2_mem_addr", bus.mem_address, 6'h3F);
        wait_free(1'b1, 1, cyc);
        check("t2_latency",  cyc,             7);
        check("t2_rdata",    bus.i_readdata,  32'hCAFEF00D);
        check("t2_d_busy",   bus.d_busywait,  1'b0);
        check("t2_no_write", write_cnt - wc0, 0);
        bus.i_read = 1'b0;
        @(negedge clock);

        // 3: D write-back 01234567 to 12
        bus.d_write = 1'b1; bus.d_address = 6'h12; bus.d_writedata = 32'h01234567;
        @(negedge clock);
        check("t3_mem_write", bus.mem_write,     1'b1);
        check("t3_mem_read",  bus.mem_read,      1'b0);
        check("t3_mem_addr",  bus.mem_address,   6'h12);
        check("t3_mem_wdata", bus.mem_writedata, 32'h01234567);
        repeat (3) @(negedge clock);
        check("t3_hold_write", bus.mem_write,     1'b1);
        check("t3_hold_wdata", bus.mem_writedata, 32'h01234567);
        wait_free(1'b0, 4, cyc);
        check("t3_latency",  cyc,           7);
        check("t3_wr_clr",   bus.mem_write, 1'b0);
        check("t3_mem_cell", mem_q[18],     32'h01234567);
        bus.d_write = 1'b0;
        @(negedge clock);

        // 4: simultaneous D and I after reset: D first, then I
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.d_read = 1'b1; bus.d_address = 6'h05;
        bus.i_read = 1'b1; bus.i_address = 6'h3F;
        @(negedge clock);
        check("t4_first_addr", bus.mem_address, 6'h05);
        wait_free(1'b0, 1, cyc);
        check("t4_d_latency",  cyc,            7);
        check("t4_d_rdata",    bus.d_readdata, 32'hDEADBEEF);
        check("t4_i_waiting",  bus.i_busywait, 1'b1);
        bus.d_read = 1'b0;
        wait_free(1'b1, 0, cyc);
        check("t4_i_latency",  cyc,            8);
        check("t4_i_rdata",    bus.i_readdata, 32'hCAFEF00D);

        // 4b: both persisting -> D, I, D, I
        bus.d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            done_l = 1'b0;
            for (int j = 0; j < BOUND && !done_l; j++) begin
                if (!bus.d_busywait || !bus.i_busywait) done_l = 1'b1;
                else @(negedge clock);
            end
            check("t4b_bound", done_l, 1'b1);
            port_seen = bus.d_busywait ? 1 : 0;
            check($sformatf("t4b_order%0d", k), port_seen, k % 2);
        end
        bus.d_read = 1'b0; bus.i_read = 1'b0;
        @(negedge clock);

        // 5: I granted, D raised during WAIT waits for its own DONE
        bus.i_read = 1'b1; bus.i_address = 6'h3F;
        repeat (3) @(negedge clock);
        bus.d_read = 1'b1; bus.d_address = 6'h05;
        done_l = 1'b0;
        for (int j = 0; j < BOUND && !done_l; j++) begin
            @(negedge clock);
            if (!bus.i_busywait) done_l = 1'b1;
            else begin
                check("t5_addr_hold", bus.mem_address, 6'h3F);
                check("t5_d_stall",   bus.d_busywait,  1'b1);
            end
        end
        check("t5_bound",   done_l,         1'b1);
        check("t5_i_rdata", bus.i_readdata, 32'hCAFEF00D);
        check("t5_d_done",  bus.d_busywait, 1'b1);
        bus.i_read = 1'b0;
        wait_free(1'b0, 0, cyc);
        check("t5_d_latency", cyc,            8);
        check("t5_d_rdata",   bus.d_readdata, 32'hDEADBEEF);
        bus.d_read = 1'b0;
        @(negedge clock);

        // 6: reset during WAIT of a D write
        bus.d_write = 1'b1; bus.d_address = 6'h12; bus.d_writedata = 32'hA5A5A5A5;
        repeat (3) @(negedge clock);
        check("t6_pre_write", bus.mem_write, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("t6_mem_write", bus.mem_write,     1'b0);
        check("t6_mem_read",  bus.mem_read,      1'b0);
        check("t6_mem_addr",  bus.mem_address,   6'h00);
        check("t6_mem_wdata", bus.mem_writedata, 32'h0);
        check("t6_rdata",     bus.d_readdata,    32'h0);
        check("t6_d_busy",    bus.d_busywait,    1'b1);
        check("t6_i_busy",    bus.i_busywait,    1'b0);
        bus.d_write = 1'b0; bus.d_read = 1'b1; bus.d_address = 6'h05;
        bus.i_read = 1'b1; bus.i_address = 6'h3F;
        reset = 1'b0;
        @(negedge clock);
        check("t6_d_wins",   bus.mem_address, 6'h05);
        wait_free(1'b0, 1, cyc);
        check("t6_d_latency", cyc,            7);
        check("t6_d_rdata",   bus.d_readdata, 32'hDEADBEEF);
        bus.d_read = 1'b0;
        wait_free(1'b1, 0, cyc);
        check("t6_i_latency", cyc,            8);
        check("t6_i_rdata",   bus.i_readdata, 32'hCAFEF00D);
        bus.i_read = 1'b0;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
